aes_iter_encrypt: RTL

//  Iterative AES-128 encryption datapath, one round per clock.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_iter_encrypt_if.sv | 23 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_iter_encrypt.sv | 126 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, the forward S-box table, GF(2^8) xtime and the
// controller state encoding used by the iterative encryption datapath.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } aes_fsm_t;

  // Entry 0 sits in the leftmost slot, so SBOX[b] is the substitution of b.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_iter_encrypt_if.sv
// Plaintext-in / ciphertext-out stream bundle of the iterative AES core.
// master = the surrounding system, slave = the encryption block.
interface aes_iter_encrypt_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_data;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box, purely combinational table lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  aes_byte_t din,
  output aes_byte_t dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES-128 encryptor, one round per clock, keys fetched from an external ROM.
// Optional macro AES_FAST_RESTART_EN lets a new block load in the same cycle the result leaves.
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int ROUND_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  aes_iter_encrypt_if.slave   bus,
  output logic [ROUND_W-1:0]  round_idx,
  input  aes_state_t          round_key
);

  aes_fsm_t           fsm_reg;
  logic [ROUND_W-1:0] rnd_reg;
  aes_state_t         state_reg;
  aes_state_t         out_data_reg;
  logic               out_valid_reg;
  logic               in_ready_c;

  aes_state_t sb_state;
  aes_state_t sr_state;
  aes_state_t mc_state;

  // Byte gi is row gi%4, column gi/4; ShiftRows rotates row r left by r columns.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub
    localparam int ROW = gi % 4;
    localparam int SRC = 4 * (((gi / 4) + ROW) % 4) + ROW;

    aes_sbox u_sbox (
      .din  (state_reg[127-8*gi -: 8]),
      .dout (sb_state[127-8*gi -: 8])
    );

    assign sr_state[127-8*gi -: 8] = sb_state[127-8*SRC -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    aes_byte_t a0, a1, a2, a3;
    assign a0 = sr_state[127-32*gi -: 8];
    assign a1 = sr_state[119-32*gi -: 8];
    assign a2 = sr_state[111-32*gi -: 8];
    assign a3 = sr_state[103-32*gi -: 8];

    assign mc_state[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc_state[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc_state[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc_state[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  // rnd_reg is held at 0 outside RUN, so it doubles as the ROM index.
  assign round_idx     = rnd_reg;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

  always_comb begin
    in_ready_c = 1'b0;
    case (fsm_reg)
      S_IDLE:  in_ready_c = 1'b1;
`ifdef AES_FAST_RESTART_EN
      S_DONE:  in_ready_c = bus.out_ready;
`endif
      default: in_ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= S_IDLE;
      rnd_reg       <= '0;
      state_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (fsm_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_reg <= bus.in_data ^ round_key;
            rnd_reg   <= ROUND_W'(1);
            fsm_reg   <= S_RUN;
          end
        end

        S_RUN: begin
          if (rnd_reg == ROUND_W'(NR)) begin
            // Final round skips MixColumns; result goes to a dedicated output register.
            out_data_reg  <= sr_state ^ round_key;
            out_valid_reg <= 1'b1;
            rnd_reg       <= '0;
            fsm_reg       <= S_DONE;
          end else begin
            state_reg <= mc_state ^ round_key;
            rnd_reg   <= rnd_reg + ROUND_W'(1);
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
`ifdef AES_FAST_RESTART_EN
            if (bus.in_valid) begin
              state_reg <= bus.in_data ^ round_key;
              rnd_reg   <= ROUND_W'(1);
              fsm_reg   <= S_RUN;
            end else begin
              fsm_reg <= S_IDLE;
            end
`else
            fsm_reg <= S_IDLE;
`endif
          end
        end

        default: begin
          fsm_reg       <= S_IDLE;
          rnd_reg       <= '0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
